axis_baser_tx_ifg_sched: RTL
============================

Name: axis_baser_tx_ifg_sched

Overview:
Inter-frame-gap scheduler for the 64-bit AXI-Stream-to-10GBASE-R transmit path. It tracks frame start/end events from the TX frame path and decides the earliest cycle and lane (0 or 4) at which the next frame may start. It applies ifg_delay, 4-byte start alignment and, optionally, deficit idle count (DIC). It sits beside the TX encoder and gates its frame-start acceptance.

Parameters:
ENABLE_DIC, 1, 1 = deficit idle count rounding; 0 = always round the gap up to the next 4-byte boundary
MIN_IFG, 4, lower clamp on ifg_delay in bytes; must be ≥4
CNT_WIDTH, 6, width of the gap word counter; must hold (8+255+3)>>3 = 33

Ports:
clk  in  1  clock; all logic on rising edge
rst  in  1  reset, synchronous, active-high
ifg_delay  in  8  configured gap in bytes; sampled only in the eof cycle
req_valid  in  1  TX path has a frame ready to start
req_ready  out  1  start permitted this cycle; handshake = req_valid & req_ready
start_lane  out  1  lane of permitted start: 0 = byte 0, 1 = byte 4; valid while req_ready=1
eof_valid  in  1  current word carries the frame end
eof_bytes  in  4  valid data bytes in the final word, 1..8; the terminate byte follows
busy  out  1  state != IDLE
deficit  out  2  current DIC deficit in bytes
err_eof  out  1  one-cycle pulse: eof_valid received outside FRAME

Behaviour:
- States: IDLE, FRAME, IFG. Registers: state, cnt[CNT_WIDTH], lane_reg, deficit[1:0], err_eof.
- Reset (rst=1, synchronous): state=IDLE, cnt=0, lane_reg=0, deficit=0, err_eof=0. req_ready is forced to 0 while rst=1. Cycle after release: req_ready=1, start_lane=0, busy=0.
- req_ready and start_lane are combinational from registers only, never from req_valid or eof_valid.
  - IDLE: req_ready=1, start_lane=0.
  - FRAME: req_ready=0.
  - IFG: req_ready=(cnt==0), start_lane=lane_reg.
- Handshake in IDLE, or in IFG with cnt==0: next state=FRAME.
- IFG with cnt==0 and req_valid=0: next state=IDLE, deficit←0.
- IFG with cnt!=0: cnt decrements each cycle.
- FRAME with eof_valid=1 (eof cycle T):
  - Clamp eb to 1..8 (0 or >8 treated as 8).
  - g = max(ifg_delay, MIN_IFG).
  - s_raw = eb + g (9-bit, byte offset from byte 0 of the eof word); m = s_raw[1:0].
  - m==0: s=s_raw, deficit unchanged.
  - ENABLE_DIC=0, m!=0: s = s_raw + (4-m).
  - ENABLE_DIC=1, deficit+m ≤ 3: s = s_raw - m, deficit += m.
  - ENABLE_DIC=1, deficit+m > 3: s = s_raw + (4-m), deficit = deficit + m - 4.
  - If s < 8: s=8, deficit←0. Starting inside the eof word is not supported.
  - cnt ← (s>>3) - 1, lane_reg ← s[2], state ← IFG.
  - Net effect: start permitted at cycle T + (s>>3) on lane s[2].
- eof_valid in IDLE or IFG: ignored for scheduling, err_eof=1 next cycle, state/cnt/deficit unchanged.
- eof_valid in the handshake cycle: state is IDLE/IFG, so it is flagged as an error, not scheduled.
- Reset mid-IFG or mid-FRAME: abandon the schedule immediately, return to IDLE, deficit=0.
- Zero extra latency: handshake at cycle T+W is honoured the same cycle.
- All arithmetic is unsigned; no other wrap-around is possible given the widths.

Decomposition:
- Shared package axis_baser_pkg holds:
  - state enum (IDLE/FRAME/IFG)
  - constant BYTES_PER_WORD=8
  - constant LANE_ALIGN=4
  - function computing {s, deficit_next} from (eb, g, deficit, enable_dic), so the bench model reuses it.
- Sub-module: none. A single module of ~150 RTL lines.

Test Plan:
1. ENABLE_DIC=0, ifg_delay=12, eof_bytes=8 at T → req_ready=0 at T+1; req_ready=1, start_lane=1 at T+2; deficit=0.
2. ENABLE_DIC=1, ifg=12, three back-to-back frames:
   - eof_bytes=1 → ready T+1, lane 1, deficit=1.
   - eof_bytes=2 → ready T+1, lane 1, deficit=3.
   - eof_bytes=5 → ready T+2, lane 1, deficit=0.
3. ENABLE_DIC=0, ifg=12, eof_bytes=1 → s=16, ready at T+2, lane 0, deficit stays 0.
4. ifg_delay=0, MIN_IFG=4, eof_bytes=1, DIC on → s=4 clamped to 8; ready T+1, lane 0, deficit=0.
5. req_valid low at the cycle cnt==0 → next cycle IDLE, deficit=0, req_ready=1, start_lane=0.
6. Error and reset:
   - eof_valid in IDLE → err_eof=1 for exactly one cycle, busy stays 0.
   - rst asserted in IFG → req_ready=0 during rst, IDLE with deficit=0 after release.

Source files
------------

// File: rtl/axis_baser_tx_ifg_sched_pkg.sv
// Shared types and gap arithmetic for the 10GBASE-R TX inter-frame-gap scheduler.
// The gap function turns the final-word byte count into the next permitted start offset.
package axis_baser_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FRAME = 2'd1,
    ST_IFG   = 2'd2
  } state_e;

  localparam int BYTES_PER_WORD = 8;
  localparam int LANE_ALIGN     = 4;
  localparam int WORD_SHIFT     = $clog2(BYTES_PER_WORD);

  typedef struct packed {
    logic [8:0] s;
    logic [1:0] deficit;
  } gap_t;

  // s is the byte offset of the next start measured from byte 0 of the eof word
  function automatic gap_t calc_gap(input logic [3:0] eb, input logic [7:0] g,
                                    input logic [1:0] deficit, input logic enable_dic);
    gap_t       r;
    logic [3:0] eb_c;
    logic [8:0] s_raw;
    logic [8:0] m9;
    logic [1:0] m;
    logic [2:0] dsum;
    eb_c  = ((eb == 4'd0) || (eb > 4'd8)) ? 4'd8 : eb;
    s_raw = {5'd0, eb_c} + {1'b0, g};
    m     = s_raw[1:0];
    m9    = {7'd0, m};
    dsum  = {1'b0, deficit} + {1'b0, m};
    if (m == 2'd0) begin
      r.s       = s_raw;
      r.deficit = deficit;
    end else if (!enable_dic) begin
      r.s       = s_raw + (9'(LANE_ALIGN) - m9);
      r.deficit = deficit;
    end else if (dsum <= 3'd3) begin
      r.s       = s_raw - m9;
      r.deficit = dsum[1:0];
    end else begin
      // dsum is 4..6 here, so its low two bits equal deficit + m - 4
      r.s       = s_raw + (9'(LANE_ALIGN) - m9);
      r.deficit = dsum[1:0];
    end
    if (r.s < 9'(BYTES_PER_WORD)) begin
      r.s       = 9'(BYTES_PER_WORD);
      r.deficit = 2'd0;
    end else begin
      r.s       = r.s;
      r.deficit = r.deficit;
    end
    return r;
  endfunction

endpackage

// File: rtl/axis_baser_tx_ifg_sched_if.sv
// Frame-start request and frame-end event bundle between the TX frame path
// (master) and the inter-frame-gap scheduler (slave).
interface axis_baser_tx_ifg_sched_if;
  logic       req_valid;
  logic       req_ready;
  logic       start_lane;
  logic       eof_valid;
  logic [3:0] eof_bytes;

  modport master (output req_valid, eof_valid, eof_bytes, input req_ready, start_lane);
  modport slave  (input req_valid, eof_valid, eof_bytes, output req_ready, start_lane);
endinterface

// File: rtl/axis_baser_tx_ifg_sched.sv
// Inter-frame-gap scheduler: decides the earliest cycle and lane (0 or 4) at which
// the next TX frame may start, honouring ifg_delay, 4-byte alignment and optional DIC.
module axis_baser_tx_ifg_sched
  import axis_baser_pkg::*;
#(
  parameter bit ENABLE_DIC = 1'b1,
  parameter int MIN_IFG    = 4,
  parameter int CNT_WIDTH  = 6
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [7:0]                       ifg_delay,
  axis_baser_tx_ifg_sched_if.slave         tx,
  output logic                             busy,
  output logic [1:0]                       deficit,
  output logic                             err_eof
);

  state_e               state_q, state_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 lane_q, lane_d;
  logic [1:0]           deficit_q, deficit_d;
  logic                 err_eof_q, err_eof_d;

  logic [7:0] g_s;
  gap_t       gap_s;
  logic       req_ready_s;
  logic       start_lane_s;
  logic       handshake_s;

  assign g_s         = (ifg_delay < 8'(MIN_IFG)) ? 8'(MIN_IFG) : ifg_delay;
  assign gap_s       = calc_gap(tx.eof_bytes, g_s, deficit_q, ENABLE_DIC);
  assign handshake_s = tx.req_valid & req_ready_s;

  // Start permission derived from registered state only, masked during reset
  always_comb begin
    req_ready_s  = 1'b0;
    start_lane_s = 1'b0;
    if (rst) begin
      req_ready_s  = 1'b0;
      start_lane_s = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          req_ready_s  = 1'b1;
          start_lane_s = 1'b0;
        end
        ST_FRAME: begin
          req_ready_s  = 1'b0;
          start_lane_s = 1'b0;
        end
        ST_IFG: begin
          req_ready_s  = (cnt_q == '0);
          start_lane_s = lane_q;
        end
        default: begin
          req_ready_s  = 1'b0;
          start_lane_s = 1'b0;
        end
      endcase
    end
  end

  // Next-state, gap countdown and deficit bookkeeping
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    lane_d    = lane_q;
    deficit_d = deficit_q;
    err_eof_d = tx.eof_valid & (state_q != ST_FRAME);
    case (state_q)
      ST_IDLE: begin
        if (handshake_s) state_d = ST_FRAME;
        else             state_d = ST_IDLE;
      end
      ST_FRAME: begin
        if (tx.eof_valid) begin
          // start lands (s >> 3) words after the eof word; cnt counts the words in between
          cnt_d     = CNT_WIDTH'(gap_s.s >> WORD_SHIFT) - CNT_WIDTH'(1);
          lane_d    = gap_s.s[2];
          deficit_d = gap_s.deficit;
          state_d   = ST_IFG;
        end else begin
          state_d = ST_FRAME;
        end
      end
      ST_IFG: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_WIDTH'(1);
        end else if (handshake_s) begin
          state_d = ST_FRAME;
        end else begin
          state_d   = ST_IDLE;
          deficit_d = 2'd0;
        end
      end
      default: begin
        state_d   = ST_IDLE;
        cnt_d     = '0;
        lane_d    = 1'b0;
        deficit_d = 2'd0;
      end
    endcase
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      lane_q    <= 1'b0;
      deficit_q <= 2'd0;
      err_eof_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      lane_q    <= lane_d;
      deficit_q <= deficit_d;
      err_eof_q <= err_eof_d;
    end
  end

  assign tx.req_ready  = req_ready_s;
  assign tx.start_lane = start_lane_s;
  assign busy          = (state_q != ST_IDLE);
  assign deficit       = deficit_q;
  assign err_eof       = err_eof_q;

endmodule
